id_exe_ctrl: RTL and testbench
==============================

// Module: id_exe_ctrl
// PURPOSE
//  ID-stage control and ID/EX pipeline register; the producer of the 4-bit ALU command.
//  Decodes the instruction held in IF/ID into exe_cmd, operand selects and MEM/WB/branch controls.
//  Registers the decoded controls toward EX.
//  Detects load-use hazards and inserts exactly one bubble for each one.
//  Applies the downstream stall and flush rules.
// PARAMETERS
//  ILL_CNT_W  8  width of the saturating illegal-instruction counter
// PORTS
//  clk            in   1   clock, rising edge
//  rst_n          in   1   asynchronous active-low reset
//  instr_i        in   32  instruction from IF/ID
//  instr_valid_i  in   1   instr_i holds a real instruction
//  pc_i           in   32  PC+4 of instr_i; passed through
//  stall_i        in   1   downstream stall: hold all registered outputs
//  flush_i        in   1   branch taken: kill the slot being loaded
//  stall_o        out  1   combinational; IF/ID must hold its contents
//  valid_o        out  1   EX slot holds a real instruction
//  exe_cmd_o      out  4   ALU command
//  src1_o/src2_o  out  5   source register numbers
//  dest_o         out  5   destination register number
//  imm_o          out  32  immediate (see BEHAVIOUR)
//  imm_sel_o      out  1   ALU in2 takes imm_o instead of src2 data
//  mem_read_o/mem_write_o/wb_en_o  out 1 each  MEM and WB controls
//  br_type_o      out  2   00 none, 01 beq, 10 bne, 11 j
//  pc_o           out  32  registered pc_i
//  illegal_o      out  1   EX slot holds an undecodable instruction
//  illegal_cnt_o  out  ILL_CNT_W  saturating count of illegal instructions issued
// BEHAVIOUR
//  Reset: every registered output is 0. A zeroed slot is a bubble.
//  exe_cmd codes: ADD 0000, SUB 0010, AND 0100, OR 0101, NOR 0110, XOR 0111,
//   SLL 1000, SRA 1001, SRL 1010. No other code is ever driven.
//  R-type (op 000000), decoded by funct:
//   add 100000, sub 100010, and 100100, or 100101, xor 100110, nor 100111.
//   Fields: src1=rs, src2=rt, dest=rd, wb=1.
//  Shifts: sll 000000, srl 000010, sra 000011.
//   src1=rt, imm={27'b0,shamt}, imm_sel=1, dest=rd, wb=1.
//  I-type: addi 001000 and lw 100011/sw 101011 use ADD with sign-extended imm.
//   andi 001100, ori 001101, xori 001110 use zero-extended imm.
//   src1=rs; dest=rt except sw (src2=rt, no wb). lw sets mem_read and wb.
//  beq 000100 / bne 000101: SUB, src1=rs, src2=rt, imm sign-extended, no wb.
//  j 000010: imm={6'b0,target26}, br_type=11, no operand use.
//  Any other op or funct is illegal:
//   drives ADD, wb/mem/br all 0, illegal=1, counter +1, saturates at all-ones.
//  Operand use: use1 = all except j. use2 = non-shift R-type, sw, beq, bne.
//  load_use = instr_valid_i & valid_o & mem_read_o & dest_o!=0
//             & ((use1 & src1==dest_o) | (use2 & src2==dest_o)).
//  stall_o = ~flush_i & (stall_i | load_use).
//  Next-state priority at each clk:
//   1. flush_i: load bubble (also when stall_i=1).
//   2. stall_i: hold all outputs, counter unchanged.
//   3. load_use: load bubble; next cycle valid_o=0, so exactly one bubble.
//   4. instr_valid_i: load decoded slot.
//   5. else: load bubble.
//  The counter increments only when an illegal slot is loaded.
//  Reset mid-stall or mid-bubble clears immediately; no pending state survives.
//  Latency: decode-to-EX is one cycle.
// STRUCTURE
//  mips_pkg holds the opcode and funct constants, EXE_* command codes and BR_* codes.
//  One sub-module, id_decode: pure combinational instr -> control bundle plus use1/use2.
//  id_exe_ctrl holds the register, hazard logic and counter.
// TESTING
//  1 Reset asserted mid-run -> all outputs 0 asynchronously; stall_o=0.
//  2 add 0x00221820 valid -> next cycle valid=1, cmd=0000, src1=1, src2=2, dest=3, wb=1.
//  3 lw 0x8C240008, then add 0x00822820 -> stall_o=1 for one cycle, one bubble,
//    then add issues with src1=4.
//  4 sra 0x000730C3 -> cmd=1001, src1=7, imm=3, imm_sel=1, dest=6.
//  5 stall_i=1 for 3 cycles -> outputs frozen; flush_i with stall_i -> bubble, stall_o=0.
//  6 300 instructions with op=111111 -> illegal=1, wb=0, cmd=0000; counter ends at 255.

Source files
------------

// File: rtl/mips_pkg.sv
// Opcode/funct constants, ALU command and branch codes, and the ID->EX control
// bundle shared by the decoder and the ID/EX register.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;

  typedef enum logic [3:0] {
    EXE_ADD = 4'b0000,
    EXE_SUB = 4'b0010,
    EXE_AND = 4'b0100,
    EXE_OR  = 4'b0101,
    EXE_NOR = 4'b0110,
    EXE_XOR = 4'b0111,
    EXE_SLL = 4'b1000,
    EXE_SRA = 4'b1001,
    EXE_SRL = 4'b1010
  } exe_cmd_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BEQ  = 2'b01,
    BR_BNE  = 2'b10,
    BR_J    = 2'b11
  } br_type_e;

  typedef struct packed {
    exe_cmd_e    exe_cmd;
    logic [4:0]  src1;
    logic [4:0]  src2;
    logic [4:0]  dest;
    logic [31:0] imm;
    logic        imm_sel;
    logic        mem_read;
    logic        mem_write;
    logic        wb_en;
    br_type_e    br_type;
    logic        illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_decode.sv
// Pure combinational decode of one instruction into the EX control bundle,
// plus the operand-use flags that feed load-use detection.
module id_decode
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        use1,
  output logic        use2
);

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic        r_arith;
  logic        r_shift;

  assign op       = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign shamt    = instr[10:6];
  assign funct    = instr[5:0];
  assign imm_sext = {{16{instr[15]}}, instr[15:0]};
  assign imm_zext = {16'b0, instr[15:0]};

  // Unmatched op/funct falls through to the illegal default: ADD, no side effects.
  always_comb begin
    ctrl         = CTRL_BUBBLE;
    ctrl.exe_cmd = EXE_ADD;
    ctrl.src1    = rs;
    ctrl.src2    = rt;
    use1         = 1'b1;
    use2         = 1'b0;
    r_arith      = 1'b0;
    r_shift      = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  begin ctrl.exe_cmd = EXE_ADD; r_arith = 1'b1; end
          FN_SUB:  begin ctrl.exe_cmd = EXE_SUB; r_arith = 1'b1; end
          FN_AND:  begin ctrl.exe_cmd = EXE_AND; r_arith = 1'b1; end
          FN_OR:   begin ctrl.exe_cmd = EXE_OR;  r_arith = 1'b1; end
          FN_XOR:  begin ctrl.exe_cmd = EXE_XOR; r_arith = 1'b1; end
          FN_NOR:  begin ctrl.exe_cmd = EXE_NOR; r_arith = 1'b1; end
          FN_SLL:  begin ctrl.exe_cmd = EXE_SLL; r_shift = 1'b1; end
          FN_SRL:  begin ctrl.exe_cmd = EXE_SRL; r_shift = 1'b1; end
          FN_SRA:  begin ctrl.exe_cmd = EXE_SRA; r_shift = 1'b1; end
          default: ctrl.illegal = 1'b1;
        endcase
        if (r_arith) begin
          ctrl.dest  = rd;
          ctrl.wb_en = 1'b1;
          use2       = 1'b1;
        end
        if (r_shift) begin
          ctrl.src1    = rt;
          ctrl.imm     = {27'b0, shamt};
          ctrl.imm_sel = 1'b1;
          ctrl.dest    = rd;
          ctrl.wb_en   = 1'b1;
        end
      end
      OP_ADDI, OP_LW: begin
        ctrl.imm      = imm_sext;
        ctrl.imm_sel  = 1'b1;
        ctrl.dest     = rt;
        ctrl.wb_en    = 1'b1;
        ctrl.mem_read = (op == OP_LW);
      end
      OP_SW: begin
        ctrl.imm       = imm_sext;
        ctrl.imm_sel   = 1'b1;
        ctrl.mem_write = 1'b1;
        use2           = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        ctrl.exe_cmd = (op == OP_ANDI) ? EXE_AND : (op == OP_ORI) ? EXE_OR : EXE_XOR;
        ctrl.imm     = imm_zext;
        ctrl.imm_sel = 1'b1;
        ctrl.dest    = rt;
        ctrl.wb_en   = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.exe_cmd = EXE_SUB;
        ctrl.imm     = imm_sext;
        ctrl.br_type = (op == OP_BEQ) ? BR_BEQ : BR_BNE;
        use2         = 1'b1;
      end
      OP_J: begin
        ctrl.src1    = 5'd0;
        ctrl.src2    = 5'd0;
        ctrl.imm     = {6'b0, instr[25:0]};
        ctrl.br_type = BR_J;
        use1         = 1'b0;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_exe_ctrl.sv
// ID-stage control: ID/EX register, load-use bubble insertion, stall/flush
// handling and a saturating count of issued illegal instructions.
module id_exe_ctrl
  import mips_pkg::*;
#(
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          instr_i,
  input  logic                 instr_valid_i,
  input  logic [31:0]          pc_i,
  input  logic                 stall_i,
  input  logic                 flush_i,
  output logic                 stall_o,
  output logic                 valid_o,
  output logic [3:0]           exe_cmd_o,
  output logic [4:0]           src1_o,
  output logic [4:0]           src2_o,
  output logic [4:0]           dest_o,
  output logic [31:0]          imm_o,
  output logic                 imm_sel_o,
  output logic                 mem_read_o,
  output logic                 mem_write_o,
  output logic                 wb_en_o,
  output logic [1:0]           br_type_o,
  output logic [31:0]          pc_o,
  output logic                 illegal_o,
  output logic [ILL_CNT_W-1:0] illegal_cnt_o
);

  ctrl_t                dec;
  ctrl_t                slot_q;
  logic                 use1;
  logic                 use2;
  logic                 valid_q;
  logic [31:0]          pc_q;
  logic [ILL_CNT_W-1:0] cnt_q;
  logic                 load_use;

  id_decode u_decode (
    .instr (instr_i),
    .ctrl  (dec),
    .use1  (use1),
    .use2  (use2)
  );

  // The bubble loaded on a hazard clears valid_q, so the replayed instruction cannot re-trigger it.
  assign load_use = instr_valid_i & valid_q & slot_q.mem_read & (slot_q.dest != 5'd0)
                  & ((use1 & (dec.src1 == slot_q.dest)) | (use2 & (dec.src2 == slot_q.dest)));

  assign stall_o = ~flush_i & (stall_i | load_use);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q  <= CTRL_BUBBLE;
      valid_q <= 1'b0;
      pc_q    <= 32'd0;
      cnt_q   <= '0;
    end else if (flush_i) begin
      slot_q  <= CTRL_BUBBLE;
      valid_q <= 1'b0;
      pc_q    <= 32'd0;
    end else if (stall_i) begin
      slot_q  <= slot_q;
      valid_q <= valid_q;
      pc_q    <= pc_q;
    end else if (load_use || !instr_valid_i) begin
      slot_q  <= CTRL_BUBBLE;
      valid_q <= 1'b0;
      pc_q    <= 32'd0;
    end else begin
      slot_q  <= dec;
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      if (dec.illegal && (cnt_q != '1))
        cnt_q <= cnt_q + ILL_CNT_W'(1);
    end
  end

  assign valid_o       = valid_q;
  assign exe_cmd_o     = slot_q.exe_cmd;
  assign src1_o        = slot_q.src1;
  assign src2_o        = slot_q.src2;
  assign dest_o        = slot_q.dest;
  assign imm_o         = slot_q.imm;
  assign imm_sel_o     = slot_q.imm_sel;
  assign mem_read_o    = slot_q.mem_read;
  assign mem_write_o   = slot_q.mem_write;
  assign wb_en_o       = slot_q.wb_en;
  assign br_type_o     = slot_q.br_type;
  assign pc_o          = pc_q;
  assign illegal_o     = slot_q.illegal;
  assign illegal_cnt_o = cnt_q;

endmodule

// File: tb/tb_id_exe_ctrl.sv
// Scoreboard bench for id_exe_ctrl: an independent decode/hazard model pushes the
// expected EX slot when stimulus is driven; it is popped and compared after the edge.
module tb_id_exe_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr_i;
  logic        instr_valid_i;
  logic [31:0] pc_i;
  logic        stall_i;
  logic        flush_i;
  logic        stall_o;
  logic        valid_o;
  logic [3:0]  exe_cmd_o;
  logic [4:0]  src1_o;
  logic [4:0]  src2_o;
  logic [4:0]  dest_o;
  logic [31:0] imm_o;
  logic        imm_sel_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic        wb_en_o;
  logic [1:0]  br_type_o;
  logic [31:0] pc_o;
  logic        illegal_o;
  logic [7:0]  illegal_cnt_o;

  typedef struct packed {
    logic        valid;
    logic [3:0]  cmd;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [4:0]  d;
    logic [31:0] imm;
    logic        isel;
    logic        mr;
    logic        mw;
    logic        wb;
    logic [1:0]  br;
    logic        ill;
    logic        u1;
    logic        u2;
    logic [31:0] pc;
    logic [7:0]  cnt;
  } exp_t;

  exp_t        expQ[$];
  exp_t        mCur;
  logic [7:0]  mCnt;
  logic [31:0] pcVal;
  int          assertCount;
  int          failCount;

  id_exe_ctrl #(.ILL_CNT_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_i       (instr_i),
    .instr_valid_i (instr_valid_i),
    .pc_i          (pc_i),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .stall_o       (stall_o),
    .valid_o       (valid_o),
    .exe_cmd_o     (exe_cmd_o),
    .src1_o        (src1_o),
    .src2_o        (src2_o),
    .dest_o        (dest_o),
    .imm_o         (imm_o),
    .imm_sel_o     (imm_sel_o),
    .mem_read_o    (mem_read_o),
    .mem_write_o   (mem_write_o),
    .wb_en_o       (wb_en_o),
    .br_type_o     (br_type_o),
    .pc_o          (pc_o),
    .illegal_o     (illegal_o),
    .illegal_cnt_o (illegal_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [31:0] mkR(input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd, input logic [4:0] sh,
                                      input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] mkI(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Reference decode written from the instruction table, with literal encodings.
  function automatic exp_t modelDecode(input logic [31:0] ins);
    exp_t        e;
    logic [31:0] se;
    logic [31:0] ze;
    se = {{16{ins[15]}}, ins[15:0]};
    ze = {16'h0000, ins[15:0]};
    e = '0;
    e.valid = 1'b1;
    e.s1 = ins[25:21];
    e.s2 = ins[20:16];
    e.u1 = 1'b1;
    case (ins[31:26])
      6'h00: begin
        case (ins[5:0])
          6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27: begin
            case (ins[5:0])
              6'h20: e.cmd = 4'h0;
              6'h22: e.cmd = 4'h2;
              6'h24: e.cmd = 4'h4;
              6'h25: e.cmd = 4'h5;
              6'h26: e.cmd = 4'h7;
              default: e.cmd = 4'h6;
            endcase
            e.d = ins[15:11]; e.wb = 1'b1; e.u2 = 1'b1;
          end
          6'h00, 6'h02, 6'h03: begin
            e.cmd = (ins[5:0] == 6'h00) ? 4'h8 : (ins[5:0] == 6'h02) ? 4'hA : 4'h9;
            e.s1 = ins[20:16]; e.imm = {27'd0, ins[10:6]}; e.isel = 1'b1;
            e.d = ins[15:11]; e.wb = 1'b1;
          end
          default: e.ill = 1'b1;
        endcase
      end
      6'h08: begin e.imm = se; e.isel = 1'b1; e.d = ins[20:16]; e.wb = 1'b1; end
      6'h23: begin e.imm = se; e.isel = 1'b1; e.d = ins[20:16]; e.wb = 1'b1; e.mr = 1'b1; end
      6'h2B: begin e.imm = se; e.isel = 1'b1; e.mw = 1'b1; e.u2 = 1'b1; end
      6'h0C: begin e.cmd = 4'h4; e.imm = ze; e.isel = 1'b1; e.d = ins[20:16]; e.wb = 1'b1; end
      6'h0D: begin e.cmd = 4'h5; e.imm = ze; e.isel = 1'b1; e.d = ins[20:16]; e.wb = 1'b1; end
      6'h0E: begin e.cmd = 4'h7; e.imm = ze; e.isel = 1'b1; e.d = ins[20:16]; e.wb = 1'b1; end
      6'h04: begin e.cmd = 4'h2; e.imm = se; e.br = 2'b01; e.u2 = 1'b1; end
      6'h05: begin e.cmd = 4'h2; e.imm = se; e.br = 2'b10; e.u2 = 1'b1; end
      6'h02: begin e.imm = {6'd0, ins[25:0]}; e.br = 2'b11; e.u1 = 1'b0; end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic compareSlot(input string tag, input exp_t e);
    checkOutput({tag, ".valid"}, 32'(valid_o), 32'(e.valid));
    checkOutput({tag, ".cmd"}, 32'(exe_cmd_o), 32'(e.cmd));
    if (e.u1) checkOutput({tag, ".src1"}, 32'(src1_o), 32'(e.s1));
    if (e.u2) checkOutput({tag, ".src2"}, 32'(src2_o), 32'(e.s2));
    checkOutput({tag, ".dest"}, 32'(dest_o), 32'(e.d));
    checkOutput({tag, ".imm"}, imm_o, e.imm);
    checkOutput({tag, ".ctl"},
                32'({imm_sel_o, mem_read_o, mem_write_o, wb_en_o, br_type_o, illegal_o}),
                32'({e.isel, e.mr, e.mw, e.wb, e.br, e.ill}));
    checkOutput({tag, ".pc"}, pc_o, e.pc);
    checkOutput({tag, ".cnt"}, 32'(illegal_cnt_o), 32'(e.cnt));
  endtask

  // One cycle: drive, check stall_o, push the expected next slot, then pop and compare.
  task automatic applyStimulus(input string tag, input logic [31:0] ins, input logic iv,
                               input logic st, input logic fl);
    exp_t d;
    exp_t nxt;
    exp_t got;
    logic lu;
    @(negedge clk);
    instr_i = ins; instr_valid_i = iv; pc_i = pcVal; stall_i = st; flush_i = fl;
    #1;
    d  = modelDecode(ins);
    lu = iv & mCur.valid & mCur.mr & (mCur.d != 5'd0)
       & ((d.u1 & (d.s1 == mCur.d)) | (d.u2 & (d.s2 == mCur.d)));
    checkOutput({tag, ".stall_o"}, 32'(stall_o), 32'(~fl & (st | lu)));
    if (fl) nxt = '0;
    else if (st) nxt = mCur;
    else if (lu || !iv) nxt = '0;
    else begin
      nxt = d;
      nxt.pc = pcVal;
      if (d.ill && mCnt != 8'hFF) mCnt = mCnt + 8'd1;
    end
    nxt.cnt = mCnt;
    mCur = nxt;
    expQ.push_back(nxt);
    pcVal = pcVal + 32'd4;
    @(posedge clk);
    #1;
    got = expQ.pop_front();
    compareSlot(tag, got);
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0; instr_valid_i = 1'b0;
    #1;
    mCur = '0; mCnt = 8'd0; expQ.delete();
    compareSlot(tag, mCur);
    checkOutput({tag, ".stall_o"}, 32'(stall_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [31:0] patterns[16];

  initial begin
    assertCount = 0; failCount = 0;
    mCur = '0; mCnt = 8'd0; pcVal = 32'h0000_1004;
    rst_n = 1'b0; instr_i = 32'd0; instr_valid_i = 1'b0; pc_i = 32'd0;
    stall_i = 1'b0; flush_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compareSlot("reset", mCur);
    checkOutput("reset.stall_o", 32'(stall_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("add", 32'h00221820, 1'b1, 1'b0, 1'b0);
    applyStimulus("lw", 32'h8C240008, 1'b1, 1'b0, 1'b0);
    applyStimulus("lu_hazard", 32'h00822820, 1'b1, 1'b0, 1'b0);
    applyStimulus("lu_replay", 32'h00822820, 1'b1, 1'b0, 1'b0);
    applyStimulus("sra", 32'h000730C3, 1'b1, 1'b0, 1'b0);

    patterns[0]  = mkR(5'd5, 5'd6, 5'd7, 5'd0, 6'h22);
    patterns[1]  = mkR(5'd8, 5'd9, 5'd10, 5'd0, 6'h24);
    patterns[2]  = mkR(5'd11, 5'd12, 5'd13, 5'd0, 6'h25);
    patterns[3]  = mkR(5'd14, 5'd15, 5'd16, 5'd0, 6'h26);
    patterns[4]  = mkR(5'd17, 5'd18, 5'd19, 5'd0, 6'h27);
    patterns[5]  = mkR(5'd0, 5'd9, 5'd10, 5'd31, 6'h00);
    patterns[6]  = mkR(5'd0, 5'd20, 5'd21, 5'd4, 6'h02);
    patterns[7]  = mkI(6'h08, 5'd3, 5'd4, 16'hFFF0);
    patterns[8]  = mkI(6'h0C, 5'd5, 5'd6, 16'h8001);
    patterns[9]  = mkI(6'h0D, 5'd7, 5'd8, 16'hF0F0);
    patterns[10] = mkI(6'h0E, 5'd9, 5'd10, 16'h1234);
    patterns[11] = mkI(6'h2B, 5'd2, 5'd9, 16'h8010);
    patterns[12] = mkI(6'h04, 5'd1, 5'd2, 16'hFFFE);
    patterns[13] = mkI(6'h05, 5'd3, 5'd4, 16'h0020);
    patterns[14] = 32'h0A00_1234;
    patterns[15] = mkR(5'd1, 5'd2, 5'd3, 5'd0, 6'h21);
    for (int i = 0; i < 16; i++) applyStimulus($sformatf("pat%0d", i), patterns[i], 1'b1, 1'b0, 1'b0);

    applyStimulus("lw_r9", mkI(6'h23, 5'd1, 5'd9, 16'h0004), 1'b1, 1'b0, 1'b0);
    applyStimulus("sw_src2_hz", mkI(6'h2B, 5'd1, 5'd9, 16'h0000), 1'b1, 1'b0, 1'b0);
    applyStimulus("sw_replay", mkI(6'h2B, 5'd1, 5'd9, 16'h0000), 1'b1, 1'b0, 1'b0);
    applyStimulus("lw_r0", mkI(6'h23, 5'd1, 5'd0, 16'h0004), 1'b1, 1'b0, 1'b0);
    applyStimulus("no_hz_r0", mkR(5'd0, 5'd0, 5'd3, 5'd0, 6'h20), 1'b1, 1'b0, 1'b0);
    applyStimulus("lw_r4", mkI(6'h23, 5'd1, 5'd4, 16'h0004), 1'b1, 1'b0, 1'b0);
    applyStimulus("invalid_hz", mkR(5'd4, 5'd2, 5'd3, 5'd0, 6'h20), 1'b0, 1'b0, 1'b0);
    applyStimulus("shift_rs_nohz", mkR(5'd0, 5'd5, 5'd6, 5'd2, 6'h00), 1'b1, 1'b0, 1'b0);

    applyStimulus("pre_stall", 32'h00221820, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus($sformatf("stall%0d", i), patterns[i], 1'b1, 1'b1, 1'b0);
    applyStimulus("stall_flush", patterns[3], 1'b1, 1'b1, 1'b1);
    applyStimulus("flush", patterns[4], 1'b1, 1'b0, 1'b1);

    applyStimulus("pre_rst", 32'h00221820, 1'b1, 1'b0, 1'b0);
    applyStimulus("rst_stall", patterns[5], 1'b1, 1'b1, 1'b0);
    doReset("rst_mid_stall");
    applyStimulus("lw_b", 32'h8C240008, 1'b1, 1'b0, 1'b0);
    applyStimulus("bubble_b", 32'h00822820, 1'b1, 1'b0, 1'b0);
    doReset("rst_mid_bubble");

    for (int i = 0; i < 300; i++)
      applyStimulus($sformatf("ill%0d", i), {6'b111111, 26'($urandom)}, 1'b1, 1'b0, 1'b0);
    applyStimulus("ill_stall", 32'hFC00_0000, 1'b1, 1'b1, 1'b0);
    applyStimulus("ill_sat", 32'hFC00_0001, 1'b1, 1'b0, 1'b0);
    checkOutput("ill_cnt_final", 32'(illegal_cnt_o), 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
